// File: rtl/schmidl_cox_autocorr.sv
// Schmidl-Cox lag-L autocorrelation P(n) and window energy R(n).
// Three-stage pipeline, one output beat per accepted sc16 input beat.
module schmidl_cox_autocorr #(
  parameter int L     = 64,
  parameter int ACC_W = 33 + $clog2(L)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [3*ACC_W+31:0]  m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam int AW    = $clog2(2 * L);
  localparam int DEPTH = 1 << AW;
  localparam int FW    = $clog2(2 * L + 1);

  localparam logic [AW-1:0] LOFF  = AW'(L);
  localparam logic [AW-1:0] L2OFF = AW'(2 * L);
  localparam logic [FW-1:0] FL    = FW'(L);
  localparam logic [FW-1:0] F2L   = FW'(2 * L);

  function automatic logic signed [31:0] mul(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    logic signed [31:0] ax;
    logic signed [31:0] bx;
    ax = {{16{a[15]}}, a};
    bx = {{16{b[15]}}, b};
    return ax * bx;
  endfunction

  function automatic logic signed [32:0] sx33(
    input logic signed [31:0] v
  );
    return {v[31], v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sxa(
    input logic signed [32:0] v
  );
    return {{(ACC_W-33){v[32]}}, v};
  endfunction

  logic            en;
  logic            s_fire;
  logic [AW-1:0]   wptr;
  logic [FW-1:0]   fill;
  logic [AW-1:0]   rd_l;
  logic [AW-1:0]   rd_2l;
  logic [31:0]     mem [DEPTH];

  logic            s1_v;
  logic [31:0]     s1_smp;
  logic            s1_last;
  logic [31:0]     s1_lag;
  logic [31:0]     s1_lag2;

  logic            s2_v;
  logic [31:0]     s2_smp;
  logic            s2_last;
  logic signed [32:0] c0_re;
  logic signed [32:0] c0_im;
  logic signed [32:0] c1_re;
  logic signed [32:0] c1_im;
  logic signed [32:0] e0;
  logic signed [32:0] e1;

  logic signed [15:0] br;
  logic signed [15:0] bi;
  logic signed [15:0] lr;
  logic signed [15:0] li;
  logic signed [15:0] kr;
  logic signed [15:0] ki;
  logic signed [32:0] c0_re_w;
  logic signed [32:0] c0_im_w;
  logic signed [32:0] c1_re_w;
  logic signed [32:0] c1_im_w;
  logic signed [32:0] e0_w;
  logic signed [32:0] e1_w;

  logic signed [ACC_W-1:0] p_re;
  logic signed [ACC_W-1:0] p_im;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] p_re_n;
  logic signed [ACC_W-1:0] p_im_n;
  logic signed [ACC_W-1:0] r_n;

  assign en            = m_axis_tready | ~m_axis_tvalid;
  assign s_axis_tready = en;
  assign s_fire        = s_axis_tvalid & en & ~clear;
  assign rd_l          = wptr - LOFF;
  assign rd_2l         = wptr - L2OFF;

  // Pipeline valids, write pointer and saturating fill counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      wptr          <= '0;
      fill          <= '0;
    end else if (clear) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      wptr          <= '0;
      fill          <= '0;
    end else if (en) begin
      s1_v          <= s_fire;
      s2_v          <= s1_v;
      m_axis_tvalid <= s2_v;
      if (s_fire) begin
        wptr <= wptr + AW'(1);
        if (fill != F2L) begin
          fill <= fill + FW'(1);
        end
      end
    end
  end

  // S1: history RAM write, lagged reads masked until history exists.
  always_ff @(posedge clk) begin
    if (s_fire) begin
      mem[wptr] <= s_axis_tdata;
      s1_smp    <= s_axis_tdata;
      s1_last   <= s_axis_tlast;
      s1_lag    <= (fill >= FL) ? mem[rd_l] : '0;
      s1_lag2   <= (fill == F2L) ? mem[rd_2l] : '0;
    end
  end

  assign br = s1_smp[31:16];
  assign bi = s1_smp[15:0];
  assign lr = s1_lag[31:16];
  assign li = s1_lag[15:0];
  assign kr = s1_lag2[31:16];
  assign ki = s1_lag2[15:0];

  // S2 products: conj(a)*b = (ar*br + ai*bi) + j(ar*bi - ai*br).
  always_comb begin
    c0_re_w = sx33(mul(lr, br)) + sx33(mul(li, bi));
    c0_im_w = sx33(mul(lr, bi)) - sx33(mul(li, br));
    c1_re_w = sx33(mul(kr, lr)) + sx33(mul(ki, li));
    c1_im_w = sx33(mul(kr, li)) - sx33(mul(ki, lr));
    e0_w    = sx33(mul(br, br)) + sx33(mul(bi, bi));
    e1_w    = sx33(mul(lr, lr)) + sx33(mul(li, li));
  end

  // S2 register: products and the sample travelling with them.
  always_ff @(posedge clk) begin
    if (s1_v & en) begin
      s2_smp  <= s1_smp;
      s2_last <= s1_last;
      c0_re   <= c0_re_w;
      c0_im   <= c0_im_w;
      c1_re   <= c1_re_w;
      c1_im   <= c1_im_w;
      e0      <= e0_w;
      e1      <= e1_w;
    end
  end

  // S3 running sums: add newest term, retire the one leaving the window.
  always_comb begin
    p_re_n = p_re + sxa(c0_re) - sxa(c1_re);
    p_im_n = p_im + sxa(c0_im) - sxa(c1_im);
    r_n    = r_acc + sxa(e0) - sxa(e1);
  end

  // S3 accumulator state, touched only by real beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_re  <= '0;
      p_im  <= '0;
      r_acc <= '0;
    end else if (clear) begin
      p_re  <= '0;
      p_im  <= '0;
      r_acc <= '0;
    end else if (s2_v & en) begin
      p_re  <= p_re_n;
      p_im  <= p_im_n;
      r_acc <= r_n;
    end
  end

  // Output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else if (s2_v & en & ~clear) begin
      m_axis_tdata <= {p_re_n, p_im_n, r_n, s2_smp};
      m_axis_tlast <= s2_last;
    end
  end

endmodule

// File: tb/tb_schmidl_cox_autocorr.sv
// Scoreboard bench for schmidl_cox_autocorr.
// Two instances: L=4 (main) and L=2 (rotating phasor).
module tb_schmidl_cox_autocorr;

  localparam int LA  = 4;
  localparam int LB  = 2;
  localparam int AWA = 35;
  localparam int AWB = 34;
  localparam int WA  = 3 * AWA + 32;
  localparam int WB  = 3 * AWB + 32;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic [31:0] sd;
  logic sl;
  logic va, vb;
  logic tra, trb;
  logic [WA-1:0] da;
  logic [WB-1:0] db;
  logic la, lb;
  logic ova, ovb;
  logic mra, mrb;
  logic bp;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_hs = -1;
  int lat_out = -1;
  bit lat_on = 0;

  logic [WA:0] qa[$];
  logic [WB:0] qb[$];
  int hr[$];
  int hi[$];
  logic [WA-1:0] lasta;
  logic [WB-1:0] lastb;

  schmidl_cox_autocorr #(.L(LA)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clr),
    .s_axis_tdata(sd), .s_axis_tlast(sl),
    .s_axis_tvalid(va), .s_axis_tready(tra),
    .m_axis_tdata(da), .m_axis_tlast(la),
    .m_axis_tvalid(ova), .m_axis_tready(mra)
  );

  schmidl_cox_autocorr #(.L(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clr),
    .s_axis_tdata(sd), .s_axis_tlast(sl),
    .s_axis_tvalid(vb), .s_axis_tready(trb),
    .m_axis_tdata(db), .m_axis_tlast(lb),
    .m_axis_tvalid(ovb), .m_axis_tready(mrb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [WA:0] got,
                     input logic [WA:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Direct windowed sums over the recorded history.
  task automatic model(input int l, output longint pr,
                       output longint pi, output longint rr);
    int n;
    longint ar, ai, br, bi;
    n = hr.size() - 1;
    pr = 0; pi = 0; rr = 0;
    for (int k = n - l + 1; k <= n; k++) begin
      if (k >= 0) begin
        br = hr[k]; bi = hi[k];
        ar = 0; ai = 0;
        if (k - l >= 0) begin
          ar = hr[k-l]; ai = hi[k-l];
        end
        pr += ar * br + ai * bi;
        pi += ar * bi - ai * br;
        rr += br * br + bi * bi;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp) mra = ($urandom_range(0, 9) >= 3);
    else mra = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && ova) begin
      if (lat_on && lat_out < 0) lat_out = cyc;
      if (qa.size() == 0) chk("a_extra", ova, 1'b0);
      else begin
        chk("a_out", {la, da}, qa[0]);
        if (mra) begin
          lasta = da;
          void'(qa.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ovb) begin
      if (qb.size() == 0) chk("b_extra", ovb, 1'b0);
      else begin
        chk("b_out", {(WA+1)'({lb, db})}, (WA+1)'(qb[0]));
        if (mrb) begin
          lastb = db;
          void'(qb.pop_front());
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [31:0] d,
                      input logic l, input bit c);
    bit acc;
    int guard;
    longint pr, pi, rr;
    sd = d; sl = l; va = !sel; vb = sel; clr = c;
    acc = 0; guard = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = sel ? trb : tra;
      if (acc && lat_on && lat_hs < 0) lat_hs = cyc;
      if (acc && !c) begin
        hr.push_back(int'($signed(d[31:16])));
        hi.push_back(int'($signed(d[15:0])));
        if (!sel) begin
          model(LA, pr, pi, rr);
          qa.push_back({l, AWA'(pr), AWA'(pi), AWA'(rr), d});
        end else begin
          model(LB, pr, pi, rr);
          qb.push_back({l, AWB'(pr), AWB'(pi), AWB'(rr), d});
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) chk("send_timeout", acc, 1'b1);
    clr = 0; va = 0; vb = 0;
    if (c) begin
      qa.delete(); qb.delete(); hr.delete(); hi.delete();
    end
  endtask

  task automatic do_clear();
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    qa.delete(); qb.delete(); hr.delete(); hi.delete();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (qa.size() != 0 || qb.size() != 0)
      chk("drain_left", qa.size() + qb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c1k;
    logic [31:0] fs;
    logic [31:0] ph [4];
    logic [AWA-1:0] ea;
    logic [AWB-1:0] eb;
    c1k = {16'd1000, 16'd0};
    fs  = {16'h8000, 16'h8000};
    ph[0] = {16'd1000, 16'd0};
    ph[1] = {16'd0, 16'd1000};
    ph[2] = {16'hFC18, 16'd0};
    ph[3] = {16'd0, 16'hFC18};
    rst_n = 0; clr = 0; sd = '0; sl = 0;
    va = 0; vb = 0; mra = 1; mrb = 1; bp = 0;
    #12;
    chk("rst_valid", ova, 1'b0);
    chk("rst_data", da, '0);
    chk("rst_last", la, 1'b0);
    chk("rst_ready", tra, 1'b1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    lat_on = 1;
    for (int i = 0; i < 12; i++) send(0, c1k, i == 11, 0);
    drain();
    lat_on = 0;
    chk("latency", lat_out - lat_hs, 3);
    ea = AWA'(4000000);
    chk("t1_r_hold", lasta[32+AWA-1:32], ea);
    chk("t1_p_re", lasta[WA-1 -: AWA], ea);
    chk("t1_p_im", lasta[WA-1-AWA -: AWA], '0);

    do_clear();
    for (int i = 0; i < 12; i++) send(1, ph[i % 4], 0, 0);
    drain();
    eb = AWB'(-2000000);
    chk("t2_p_re", lastb[WB-1 -: AWB], eb);
    chk("t2_p_im", lastb[WB-1-AWB -: AWB], '0);
    eb = AWB'(2000000);
    chk("t2_r", lastb[32+AWB-1:32], eb);

    do_clear();
    for (int i = 0; i < 16; i++) send(0, fs, i == 15, 0);
    drain();
    ea = AWA'(64'd8589934592);
    chk("t3_r", lasta[32+AWA-1:32], ea);
    chk("t3_p_re", lasta[WA-1 -: AWA], ea);
    chk("t3_p_im", lasta[WA-1-AWA -: AWA], '0);

    do_clear();
    bp = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(0, $urandom, $urandom_range(0, 7) == 0, 0);
    end
    drain();
    bp = 0;

    do_clear();
    for (int i = 0; i < 10; i++) send(0, c1k, 0, 0);
    send(0, c1k, 0, 1);
    for (int i = 0; i < 4; i++) send(0, c1k, i == 3, 0);
    drain();
    ea = AWA'(4000000);
    chk("t5_r", lasta[32+AWA-1:32], ea);
    chk("t5_p_re", lasta[WA-1 -: AWA], '0);

    for (int i = 0; i < 6; i++) send(0, c1k, 0, 0);
    #1;
    rst_n = 0;
    #1;
    chk("rst_async_valid", ova, 1'b0);
    chk("rst_async_ready", tra, 1'b1);
    @(posedge clk); #1;
    rst_n = 1;
    qa.delete(); qb.delete(); hr.delete(); hi.delete();
    for (int i = 0; i < 4; i++) send(0, c1k, i == 3, 0);
    drain();
    chk("t6_r", lasta[32+AWA-1:32], ea);
    chk("t6_p_re", lasta[WA-1 -: AWA], '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/schmidl_cox_autocorr.md
Name: schmidl_cox_autocorr

Overview:
- Streaming Schmidl-Cox metric core, the first user-logic stage after the noc_shell_schmidl_cox payload output (m_in_payload_*).
- For each accepted sc16 sample r(n) it computes the lag-L complex autocorrelation P(n) and the window energy R(n).
- It emits both values, together with the sample delayed, to the downstream peak/plateau detector.
- One output beat is produced per input beat; the block is fully backpressurable.

Parameters:
- L, 64: correlation half-length in samples; minimum 2, any integer.
- ACC_W, 33+$clog2(L): accumulator width; signed for P, unsigned-representable for R.

Ports:
- clk  in  1  processing clock, the axis_data_clk domain.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous one-cycle pulse; zeroes history and accumulators.
- s_axis_tdata  in  32  sc16 sample: I = [31:16], Q = [15:0], both two's complement.
- s_axis_tlast  in  1  packet end, passed through.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  3*ACC_W+32  packed as {P_re, P_im, R, sample}, MSB first.
- m_axis_tlast  out  1  tlast aligned with its sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - Accumulators=0, fill counter=0, write pointer=0, all pipeline valids=0.
  - s_axis_tready follows the stall rule below, so it reads 1 during reset.
- Definitions, with n counting accepted samples from 0 after reset or clear:
  - c(n) = conj(r(n-L))*r(n).
  - P(n) = P(n-1) + c(n) - c(n-L).
  - R(n) = R(n-1) + |r(n)|^2 - |r(n-L)|^2.
  - Any r(k) with k<0 is treated as 0.
- History storage:
  - Circular buffer of depth 2^clog2(2L) holds r; it is inferred as RAM with no reset.
  - A fill counter saturates at 2L. Reads of r(n-L) and r(n-2L) are forced to 0 while the fill counter is below L or 2L respectively.
- Arithmetic:
  - Products are full precision: 16x16 gives 32 bits; complex sums are 33 bits.
  - Accumulators are ACC_W wide with no saturation; ACC_W is sized so overflow is impossible.
  - R is never negative.
- Pipeline, 3 stages:
  - S1 registers the sample and reads r(n-L) and r(n-2L).
  - S2 computes c(n), c(n-L), |r(n)|^2 and |r(n-L)|^2.
  - S3 updates the accumulators and registers the output.
- Latency: 3 clk from input handshake to m_axis_tvalid when the output is not stalled.
- Handshake:
  - Global enable en = m_axis_tready | ~m_axis_tvalid.
  - s_axis_tready = en.
  - All stages advance only when en=1.
  - Accumulator, pointer and fill state change only on stage-valid & en, so bubbles never corrupt the sums.
  - m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- tlast: passes through with its sample and has no effect on the accumulators; the metric runs across packet boundaries.
- clear:
  - Zeroes the accumulators, the fill counter and all pipeline valids on the next edge; in-flight beats are dropped.
  - An input beat presented in the same cycle as clear is dropped; s_axis_tready stays asserted.
- Reset mid-stream: same as clear, asynchronously; m_axis_tvalid drops immediately.

Test Plan:
- L=4, constant r=(1000,0) for 12 beats, m_axis_tready=1:
  - R climbs 1e6, 2e6, 3e6, then holds at 4e6 from n=3.
  - P_re climbs to 4e6 from n=7; P_re=0 for n<4.
  - P_im=0 throughout.
  - First output appears 3 clk after the first handshake.
- L=2, r(n)=1000*j^n, i.e. (1000,0),(0,1000),(-1000,0),(0,-1000),...:
  - Steady state P=(-2000000,0) and R=2000000.
- L=4, full-scale r=(-32768,-32768) for 16 beats:
  - R=4*2^31=8589934592 and P_re=8589934592, P_im=0, with no wrap.
- Backpressure, L=4, random m_axis_tready with 30% low duty over 200 random samples:
  - Output sequence is bit-exact to a reference model with no drops or duplicates.
  - Data is held stable while stalled; tlast positions are preserved.
- clear asserted after 10 constant samples, then 4 more (1000,0) samples are sent:
  - Outputs match a fresh start: R=1e6..4e6 and P=0.
  - Beats in flight at clear never appear.
- rst_n pulsed low for 1 clk mid-stream:
  - m_axis_tvalid=0 asynchronously.
  - After release the sequence restarts from n=0, identical to the clear case.
